// File: rtl/dphy_pkg.sv
// Shared definitions for the D-PHY lane receiver.
//   dphy_state_t    : receiver FSM states
//   DPHY_SYNC_BYTE  : default HS leader/sync pattern (compared LSB-first)
//   DPHY_MAX_HUNT   : default number of sampled bits allowed while hunting
package dphy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_RECV    = 2'd2,
        ST_WAIT_LP = 2'd3
    } dphy_state_t;

    localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;
    localparam int         DPHY_MAX_HUNT  = 32;

endpackage

// File: rtl/dphy_deser8.sv
// 8-bit LSB-first deserialiser: right-shifting register plus 3-bit bit counter.
//   clk, rst  : clock, synchronous active-high reset
//   shift_en  : shift bit_in into bit 7 this cycle
//   bit_in    : serial bit
//   clr       : restart; register cleared (holding only bit_in if shift_en), counter to 0
//   byte_out  : register contents including this cycle's bit, {bit_in, shreg[7:1]}
//   byte_done : this cycle's shift completes the 8th bit since the last clr
module dphy_deser8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       bit_in,
    input  logic       clr,
    output logic [7:0] byte_out,
    output logic       byte_done
);

    logic [7:0] shreg;
    logic [2:0] cnt;

    assign byte_out  = {bit_in, shreg[7:1]};
    assign byte_done = shift_en && !clr && (cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= 8'h00;
            cnt   <= 3'd0;
        end else if (clr) begin
            shreg <= shift_en ? {bit_in, 7'b0} : 8'h00;
            cnt   <= 3'd0;
        end else if (shift_en) begin
            shreg <= byte_out;
            cnt   <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/dphy_lane_rx.sv
// D-PHY HS lane receiver: hunts for the sync byte, then assembles payload bytes.
//   clk, rst        : clock, synchronous active-high reset
//   hs_en           : lane in HS mode; a bit is sampled only when high
//   serial_data_in  : serial bit, LSB of each byte first
//   byte_data       : last assembled payload byte (held between bytes)
//   byte_valid      : one-cycle pulse, byte_data is new
//   sot             : one-cycle pulse, sync found
//   eot             : one-cycle pulse, HS burst ended while receiving
//   sync_err        : one-cycle pulse, hunt timeout
//   busy            : receiver not idle
module dphy_lane_rx
    import dphy_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DPHY_SYNC_BYTE,
    parameter int         MAX_HUNT  = DPHY_MAX_HUNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_en,
    input  logic       serial_data_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       sot,
    output logic       eot,
    output logic       sync_err,
    output logic       busy
);

    localparam int              HUNT_W    = $clog2(MAX_HUNT + 1);
    localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(MAX_HUNT - 1);

    dphy_state_t       state_q, state_d;
    logic [HUNT_W-1:0] hunt_cnt;
    logic              shift_en, clr, byte_done;
    logic [7:0]        assembled;
    logic              sot_d, eot_d, err_d, vld_d;
    logic [7:0]        data_d;

    dphy_deser8 u_deser (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .bit_in    (serial_data_in),
        .clr       (clr),
        .byte_out  (assembled),
        .byte_done (byte_done)
    );

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        clr      = 1'b0;
        sot_d    = 1'b0;
        eot_d    = 1'b0;
        err_d    = 1'b0;
        vld_d    = 1'b0;
        data_d   = byte_data;
        case (state_q)
            ST_IDLE: begin
                // The first HS bit is already captured as we leave IDLE.
                if (hs_en) begin
                    state_d  = ST_HUNT;
                    shift_en = 1'b1;
                    clr      = 1'b1;
                end
            end
            ST_HUNT: begin
                if (!hs_en) begin
                    state_d = ST_IDLE;
                end else begin
                    shift_en = 1'b1;
                    // A match wins over a timeout in the same cycle; the clr
                    // restarts the bit counter for the payload.
                    if (assembled == SYNC_BYTE) begin
                        clr     = 1'b1;
                        sot_d   = 1'b1;
                        state_d = ST_RECV;
                    end else if (hunt_cnt == HUNT_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_LP;
                    end
                end
            end
            ST_RECV: begin
                if (!hs_en) begin
                    eot_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (byte_done) begin
                        vld_d  = 1'b1;
                        data_d = assembled;
                    end
                end
            end
            ST_WAIT_LP: begin
                if (!hs_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hunt_cnt   <= '0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            sot        <= 1'b0;
            eot        <= 1'b0;
            sync_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_data  <= data_d;
            byte_valid <= vld_d;
            sot        <= sot_d;
            eot        <= eot_d;
            sync_err   <= err_d;
            busy       <= (state_d != ST_IDLE);
            // hunt_cnt counts bits sampled since leaving IDLE.
            if (state_q == ST_IDLE && hs_en)
                hunt_cnt <= HUNT_W'(1);
            else if (state_q == ST_HUNT && hs_en)
                hunt_cnt <= hunt_cnt + HUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dphy_lane_rx.sv
module tb_dphy_lane_rx;

    localparam logic [7:0] SYNC = 8'hB8;
    localparam int         MAXH = 32;
    localparam int M_IDLE = 0, M_HUNT = 1, M_RECV = 2, M_WAIT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_en = 1'b0;
    logic       serial_data_in = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid, sot, eot, sync_err, busy;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         m_mode = M_IDLE;
    logic [7:0] m_window = 8'h00;
    int         m_hunted = 0;
    bit         m_pay[$];
    logic [7:0] e_data = 8'h00;
    logic       e_vld = 0, e_sot = 0, e_eot = 0, e_err = 0, e_busy = 0;

    // event log for directed scenarios
    int cnum = 0;
    int n_sot = 0, n_eot = 0, n_err = 0, n_vld = 0;
    int at_sot = -1, at_vld_first = -1, at_vld_last = -1, busy_low = 0;

    dphy_lane_rx dut (
        .clk            (clk),
        .rst            (rst),
        .hs_en          (hs_en),
        .serial_data_in (serial_data_in),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .sot            (sot),
        .eot            (eot),
        .sync_err       (sync_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cnum);
        end
    endtask

    // One step of the behavioural receiver: what the outputs must read after this edge.
    task automatic model_step(input logic r, input logic h, input logic d);
        logic [7:0] v;
        e_sot = 0; e_eot = 0; e_err = 0; e_vld = 0;
        if (r) begin
            m_mode = M_IDLE;
            e_data = 8'h00;
        end else begin
            case (m_mode)
                M_IDLE: if (h) begin
                    m_window = {d, 7'b0};
                    m_hunted = 1;
                    m_mode   = M_HUNT;
                end
                M_HUNT: if (!h) m_mode = M_IDLE;
                    else begin
                        m_window = {d, m_window[7:1]};
                        m_hunted++;
                        if (m_window == SYNC) begin
                            e_sot = 1; m_mode = M_RECV; m_pay.delete();
                        end else if (m_hunted >= MAXH) begin
                            e_err = 1; m_mode = M_WAIT;
                        end
                    end
                M_RECV: if (!h) begin
                        e_eot = 1; m_mode = M_IDLE;
                    end else begin
                        m_pay.push_back(d);
                        if (m_pay.size() == 8) begin
                            v = 0;
                            for (int i = 0; i < 8; i++) if (m_pay[i]) v = v + 8'(1 << i);
                            e_data = v; e_vld = 1; m_pay.delete();
                        end
                    end
                default: if (!h) m_mode = M_IDLE;
            endcase
        end
        e_busy = (m_mode != M_IDLE);
    endtask

    task automatic cyc(input logic r, input logic h, input logic d);
        rst = r; hs_en = h; serial_data_in = d;
        @(posedge clk);
        model_step(r, h, d);
        #1;
        cnum++;
        check("byte_valid", byte_valid, e_vld);
        check("byte_data", byte_data, e_data);
        check("sot", sot, e_sot);
        check("eot", eot, e_eot);
        check("sync_err", sync_err, e_err);
        check("busy", busy, e_busy);
        check("pulse_excl", 32'(int'(sot) + int'(eot) + int'(sync_err) > 1), 0);
        if (sot) begin n_sot++; at_sot = cnum + 1; end
        if (eot) n_eot++;
        if (sync_err) n_err++;
        if (byte_valid) begin
            n_vld++;
            if (at_vld_first < 0) at_vld_first = cnum + 1;
            at_vld_last = cnum + 1;
        end
        if (!busy) busy_low++;
    endtask

    task automatic clear_ev();
        cnum = 0; n_sot = 0; n_eot = 0; n_err = 0; n_vld = 0;
        at_sot = -1; at_vld_first = -1; at_vld_last = -1; busy_low = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) cyc(0, 1, b[i]);
    endtask

    initial begin
        int junk, nb, part;
        // reset state
        cyc(1, 0, 0);
        cyc(1, 1, 1);
        check("rst_data", byte_data, 8'h00);
        check("rst_busy", busy, 0);

        // sync then 0xA5
        cyc(0, 0, 0);
        clear_ev();
        send_byte(8'hB8);
        send_byte(8'hA5);
        check("t29_sot_cycle", at_sot, 9);
        check("t29_vld_cycle", at_vld_first, 17);
        check("t29_data", byte_data, 8'hA5);
        check("t29_busy_low", busy_low, 0);
        cyc(0, 0, 0);
        check("t29_eot", n_eot, 1);

        // junk, sync, two bytes
        clear_ev();
        cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 0);
        send_byte(8'hB8); send_byte(8'h3C);
        check("t30_data1", byte_data, 8'h3C);
        send_byte(8'hFF);
        check("t30_data2", byte_data, 8'hFF);
        check("t30_sot", n_sot, 1);
        check("t30_vld", n_vld, 2);
        check("t30_gap", at_vld_last - at_vld_first, 8);
        cyc(0, 0, 0);

        // hunt timeout
        clear_ev();
        for (int i = 0; i < 32; i++) cyc(0, 1, 0);
        check("t31_err", n_err, 1);
        check("t31_sot", n_sot, 0);
        check("t31_vld", n_vld, 0);
        cyc(0, 1, 1); cyc(0, 1, 0);
        check("t31_busy_wait", busy, 1);
        check("t31_busy_low", busy_low, 0);
        cyc(0, 0, 0);
        check("t31_idle", busy, 0);
        check("t31_eot", n_eot, 0);

        // sync, 5 bits, drop
        clear_ev();
        send_byte(8'hB8);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);
        cyc(0, 0, 0);
        check("t32_eot", n_eot, 1);
        check("t32_vld", n_vld, 0);
        check("t32_data", byte_data, 8'hFF);

        // sync, 7 bits, drop on 8th
        clear_ev();
        send_byte(8'hB8);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("t33_eot", n_eot, 1);
        check("t33_vld", n_vld, 0);

        // reset mid-payload
        clear_ev();
        send_byte(8'hB8);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1);
        cyc(1, 1, 1);
        check("t33r_out", {byte_data, byte_valid, sot, eot, sync_err, busy}, 0);
        cyc(0, 0, 0);
        check("t33r_eot", n_eot, 0);

        // randomized bursts
        for (int b = 0; b < 150; b++) begin
            repeat ($urandom_range(1, 3)) cyc(0, 0, 1'($urandom));
            junk = $urandom_range(0, 40);
            for (int j = 0; j < junk; j++) cyc(0, 1, 1'($urandom));
            if ($urandom_range(0, 3) != 0) send_byte(SYNC);
            nb = $urandom_range(0, 4);
            for (int j = 0; j < nb; j++) send_byte(8'($urandom));
            part = $urandom_range(0, 7);
            for (int j = 0; j < part; j++) cyc(0, 1, 1'($urandom));
            if ($urandom_range(0, 9) == 0) cyc(1, 1'($urandom), 1'($urandom));
        end
        cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dphy_lane_rx.md
DPHY_LANE_RX -- requirements
Module: dphy_lane_rx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hB8, the HS leader/sync pattern, compared LSB-first.
REQ-002 SHALL have parameter MAX_HUNT, default 32, the number of sampled bits allowed in HUNT before sync is declared lost.
REQ-003 SHALL use one clock and a synchronous, active-high reset; every flop SHALL be clocked on the rising edge of clk.
REQ-004 clk  input  1  sole clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 hs_en  input  1  lane in HS mode; a bit is sampled only in cycles where hs_en=1.
REQ-007 serial_data_in  input  1  serial lane bit from transmitter, LSB of each byte first.
REQ-008 byte_data  output  8  last assembled payload byte; holds its value between bytes.
REQ-009 byte_valid  output  1  one-cycle pulse; byte_data is new.
REQ-010 sot  output  1  one-cycle pulse; sync found, start of transmission.
REQ-011 eot  output  1  one-cycle pulse; HS burst ended while in RECV.
REQ-012 sync_err  output  1  one-cycle pulse; hunt timeout.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, HUNT, RECV and WAIT_LP.
REQ-015 IDLE: when hs_en=1, go to HUNT and sample the bit in that same cycle; clear the shift register to 0 and the hunt counter to 1.
REQ-016 Shift register: 8 bits, shifts right, each new bit enters at bit 7.
REQ-017 HUNT: each sampled bit is compared against SYNC_BYTE as {new bit, shreg[7:1]}.
- On a match: sot=1 the next cycle, go to RECV, bit counter = 0.
- On no match: the hunt counter increments.
REQ-018 HUNT: when the hunt counter reaches MAX_HUNT without a match, pulse sync_err the next cycle and go to WAIT_LP; if match and timeout occur in the same cycle, the match wins.
REQ-019 HUNT with hs_en=0: return to IDLE with no pulses.
REQ-020 RECV with hs_en=1: shift the bit in and increment the 3-bit bit counter, wrapping 7->0.
- On the 8th bit: byte_data <= assembled byte and byte_valid=1 on the following cycle (latency 1 clk after the 8th bit is sampled).
REQ-021 RECV with hs_en=0: pulse eot the next cycle, discard partial bits, go to IDLE; no byte_valid is issued for a partial byte, including when hs_en falls in what would have been the 8th-bit cycle.
REQ-022 WAIT_LP: ignore serial_data_in; go to IDLE when hs_en=0, with no eot.
REQ-023 All outputs SHALL be registered; at most one of sot, eot and sync_err SHALL be high in any cycle.
REQ-024 Back-to-back bytes SHALL produce byte_valid every 8 sampled cycles with no gap or loss.

Reset
REQ-025 rst=1 SHALL force state IDLE, shift register, counters, byte_data=8'h00 and byte_valid, sot, eot, sync_err and busy all 0 on the next edge; it overrides all other inputs.
REQ-026 rst asserted mid-RECV or mid-HUNT SHALL produce no eot, sync_err or byte_valid.

Structure
REQ-027 Shared package dphy_pkg SHALL hold the state enum typedef, the default SYNC_BYTE constant and the default MAX_HUNT constant.
REQ-028 The shift register plus bit counter SHALL be one sub-module, dphy_deser8, with inputs shift_en, bit and clr and outputs byte and byte_done; the FSM stays in dphy_lane_rx.

Verification
REQ-029 Drive reset, then hs_en=1 with 0xB8 then 0xA5 LSB-first, as 16 bits starting at cycle 1. Required: sot at cycle 9; byte_valid at cycle 17 with byte_data=0xA5; busy=1 throughout.
REQ-030 Send 3 junk bits 1,1,0, then 0xB8, 0x3C, 0xFF. Required: exactly one sot; byte_valid twice, with byte_data 0x3C then 0xFF, 8 cycles apart.
REQ-031 Send 32 bits of 0x00 with hs_en=1. Required: sync_err pulses once after the 32nd bit; no sot and no byte_valid; busy stays 1 until hs_en=0, then IDLE.
REQ-032 Send sync, then 5 payload bits, then hs_en=0. Required: eot pulses once; no byte_valid; byte_data unchanged.
REQ-033 Send sync, then 7 bits, then hs_en=0 in the 8th-bit cycle. Required: eot and no byte_valid. Separately, assert rst after 4 payload bits: all outputs 0 next cycle, no eot.
